systolic_skew_feeder: RTL and testbench
=======================================

# systolic_skew_feeder

- Input-side sequencer for the N×N output-stationary systolic array of PE_SO elements.
- Accepts one k-step per handshake: a column of A and a row of B.
- Applies the triangular skew so that row i / column j data enter the array edge delayed by i / j cycles, and drives the array's `enable` and active-low accumulator clear.
- Inserts zero bubbles when upstream stalls, flushes the array after the last k-step, and pulses `done` when every psum is final.

## Interface
Parameters:
- `N`, 4: array dimension (rows = columns).
- `DATA_WIDTH`, 16: signed operand width.
- `K_MAX`, 64: maximum inner dimension; `KW` = $clog2(K_MAX+1).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a tile; sampled only in IDLE.
- `k_len`  in  KW  inner dimension K, latched when `start` is accepted.
- `in_valid`  in  1  `a_vec`/`b_vec` valid.
- `in_ready`  out  1  feeder accepts a k-step.
- `a_vec`  in  N*DATA_WIDTH  A[i][k] in slice i.
- `b_vec`  in  N*DATA_WIDTH  B[k][j] in slice j.
- `a_edge`  out  N*DATA_WIDTH  slice i drives A_in of PE(i,0).
- `b_edge`  out  N*DATA_WIDTH  slice j drives B_in of PE(0,j).
- `pe_enable`  out  1  array accumulate enable.
- `pe_clr_n`  out  1  array accumulator clear, active low.
- `busy`  out  1  not IDLE.
- `done`  out  1  one-cycle pulse: all psums final.

## Operation
- **States:** IDLE → CLEAR → FEED → FLUSH → DONE → IDLE.
- **IDLE**
  - `start`=1 at an edge → CLEAR; `k_len` is latched.
  - `start` is ignored in every other state.
- **CLEAR**
  - Lasts 1 cycle; `pe_clr_n`=0.
  - All skew registers load zero.
  - Next state is FEED, or DONE if latched K=0.
- **FEED**
  - `in_ready`=1.
  - A handshake (`in_valid`&&`in_ready` at an edge) pushes `a_vec`/`b_vec` into lane stage 0 and increments the k counter.
  - No handshake: zeros are pushed (bubble); the skew still shifts.
  - After the K-th handshake → FLUSH.
- **FLUSH**
  - Lasts exactly 2N-1 cycles; lane inputs are zero; `in_ready`=0.
  - A flush counter counts 0..2N-2, then → DONE.
- **DONE**
  - Lasts 1 cycle; `done`=1, `pe_enable`=0 → IDLE.
  - Psums hold because the array is disabled.
- **Skew lanes**
  - Lane i (A row i and B column j=i) is a shift chain of i+1 registers.
  - Lane output = the value pushed i+1 edges earlier.
  - An element accepted at edge e appears on slice i during the cycle after edge e+i.
  - It meets its partner in PE(i,j) and accumulates at edge e+i+j+1.
- **Controls**
  - `pe_enable` = 1 in FEED and FLUSH, 0 otherwise.
  - Bubbles are zero×zero, so they never corrupt sums or alignment.
  - `pe_clr_n` = ~(`rst` | state==CLEAR), combinational.
- **Arithmetic:** none; data pass through bit-exact, signed.

## Timing
- **Reset values:** state IDLE; skew registers 0; `a_edge`=`b_edge`=0; `in_ready`=0; `pe_enable`=0; `pe_clr_n`=0 (while `rst` high); `busy`=0; `done`=0.
- **Start:**
  - `start` at edge s → CLEAR in cycle s+1.
  - FEED from cycle s+2; `in_ready` is first high then.
- **Latency:** with no stalls, `done` is high exactly K+2N+1 cycles after the `start` edge (CLEAR 1 + FEED K + FLUSH 2N-1 + 1).
- **Stalls:** each FEED cycle without a handshake adds one cycle.
- **K=0:** CLEAR, then DONE in the next cycle; psums = 0.
- **Reset mid-operation** (any state):
  - Next cycle is IDLE with zeroed lanes.
  - `pe_clr_n` is low during reset, so array psums are cleared.
  - `done` is not emitted.
- **`start` asserted during DONE:** ignored; it must be re-asserted in IDLE.
- **`in_valid` while not FEED:** ignored; no data consumed.

## Test plan
- **Back-to-back all-ones:** N=4, K=4, `in_valid` held 1, all A=B=1 → exactly 4 handshakes; `done` in cycle s+13; every PE psum = 4.
- **Skew check:** K=1, a_vec={1,2,3,4}, b_vec={5,6,7,8} → slice i nonzero only in cycle (handshake edge)+i+1; PE(i,j) psum = (i+1)(j+5), e.g. PE(3,3)=32.
- **Random stalls:** random 4×4 signed matrices, K=8, `in_valid` randomly 50% → psums equal the reference A·B; `done` delay = 17 + stall count; `in_ready` low outside FEED.
- **K=0 and start-ignore:** K=0 → `pe_clr_n` low 1 cycle, `done` two cycles after `start`, `in_ready` never high; a `start` pulse during FEED changes nothing.
- **Reset mid-FEED:** `rst` after 2 of 4 handshakes → outputs return to reset values next cycle, no `done`; a fresh tile afterward gives correct psums.
- **Signed extremes:** A=-32768, B=-32768, K=2 at PE(0,0) → psum = 2^31 wraps per ACC_WIDTH=32 to -2147483648; the feeder passes operands bit-exact.

Source files
------------

// File: rtl/systolic_skew_feeder.sv
// Input-side sequencer for an NxN output-stationary systolic array: triangular
// operand skew, zero bubbles on upstream stalls, array flush and done pulse.
module systolic_skew_feeder #(
  parameter  int N          = 4,
  parameter  int DATA_WIDTH = 16,
  parameter  int K_MAX      = 64,
  localparam int KW         = $clog2(K_MAX + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [KW-1:0]           k_len,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N*DATA_WIDTH-1:0] a_vec,
  input  logic [N*DATA_WIDTH-1:0] b_vec,
  output logic [N*DATA_WIDTH-1:0] a_edge,
  output logic [N*DATA_WIDTH-1:0] b_edge,
  output logic                    pe_enable,
  output logic                    pe_clr_n,
  output logic                    busy,
  output logic                    done
);

  // state   | meaning
  // S_IDLE  | waiting for start
  // S_CLEAR | one cycle of array accumulator clear, lanes zeroed
  // S_FEED  | accepting k-steps, bubbles pushed on stall cycles
  // S_FLUSH | 2N-1 cycles of zeros to drain the skew through the array
  // S_DONE  | one-cycle done pulse, array disabled so psums hold
  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_FLUSH,
    S_DONE
  } state_t;

  localparam int FW = $clog2(2 * N);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(2 * N - 2);

  state_t          state_q, state_d;
  logic [KW-1:0]   k_len_q, k_len_d;
  logic [KW-1:0]   k_cnt_q, k_cnt_d;
  logic [FW-1:0]   f_cnt_q, f_cnt_d;
  logic            handshake;
  logic            clr_lanes;

  assign in_ready  = (state_q == S_FEED);
  assign handshake = in_valid && in_ready;
  assign clr_lanes = (state_q == S_CLEAR);
  assign pe_enable = (state_q == S_FEED) || (state_q == S_FLUSH);
  assign pe_clr_n  = ~(rst | (state_q == S_CLEAR));
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_len_q <= '0;
      k_cnt_q <= '0;
      f_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      k_len_q <= k_len_d;
      k_cnt_q <= k_cnt_d;
      f_cnt_q <= f_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_len_d = k_len_q;
    k_cnt_d = k_cnt_q;
    f_cnt_d = f_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
          k_len_d = k_len;
          k_cnt_d = '0;
          f_cnt_d = '0;
        end
      end
      S_CLEAR: begin
        state_d = (k_len_q == '0) ? S_DONE : S_FEED;
      end
      S_FEED: begin
        if (handshake) begin
          k_cnt_d = k_cnt_q + KW'(1);
          if (k_cnt_q + KW'(1) == k_len_q) begin
            state_d = S_FLUSH;
            f_cnt_d = '0;
          end
        end
      end
      S_FLUSH: begin
        if (f_cnt_q == FLUSH_LAST) begin
          state_d = S_DONE;
        end else begin
          f_cnt_d = f_cnt_q + FW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Lane i is i+1 registers deep, so its output lags stage 0 by i cycles.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DATA_WIDTH-1:0] a_sr_q [i+1];
    logic [DATA_WIDTH-1:0] b_sr_q [i+1];

    always_ff @(posedge clk) begin
      if (rst || clr_lanes) begin
        for (int s = 0; s <= i; s++) begin
          a_sr_q[s] <= '0;
          b_sr_q[s] <= '0;
        end
      end else begin
        a_sr_q[0] <= handshake ? a_vec[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        b_sr_q[0] <= handshake ? b_vec[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        for (int s = 1; s <= i; s++) begin
          a_sr_q[s] <= a_sr_q[s-1];
          b_sr_q[s] <= b_sr_q[s-1];
        end
      end
    end

    assign a_edge[i*DATA_WIDTH +: DATA_WIDTH] = a_sr_q[i];
    assign b_edge[i*DATA_WIDTH +: DATA_WIDTH] = b_sr_q[i];
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder: lane-history and PE-array models, tile
// latency, handshake window and psum checks against a plain matrix product.
module tb_systolic_skew_feeder;
  localparam int N     = 4;
  localparam int DW    = 16;
  localparam int K_MAX = 64;
  localparam int KW    = $clog2(K_MAX + 1);

  logic            clk = 1'b0;
  logic            rst, start, in_valid;
  logic [KW-1:0]   k_len;
  logic [N*DW-1:0] a_vec, b_vec, a_edge, b_edge;
  logic            in_ready, pe_enable, pe_clr_n, busy, done;

  always #5 clk = ~clk;

  systolic_skew_feeder #(.N(N), .DATA_WIDTH(DW), .K_MAX(K_MAX)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_vec(a_vec), .b_vec(b_vec), .a_edge(a_edge), .b_edge(b_edge),
    .pe_enable(pe_enable), .pe_clr_n(pe_clr_n), .busy(busy), .done(done)
  );

  int vectors = 0;
  int miscompares = 0;
  bit chk_on = 1'b0;
  bit exp_ready = 1'b0;

  logic [N*DW-1:0]        hist_a [N];
  logic [N*DW-1:0]        hist_b [N];
  logic signed [DW-1:0]   ar [N][N];
  logic signed [DW-1:0]   br [N][N];
  logic signed [DW-1:0]   m_ain, m_bin;
  int                     acc [N][N];
  logic signed [DW-1:0]   ma [N][K_MAX];
  logic signed [DW-1:0]   mb [K_MAX][N];
  int                     ref_p [N][N];

  typedef struct {
    int k;
    int fill;
    int lat;
    int p00;
    int p33;
  } vec_t;
  vec_t tbl [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // History of what should have entered stage 0 at each edge, plus a
  // behavioural output-stationary array fed by the DUT edge outputs.
  initial forever begin
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        hist_a[i] = '0;
        hist_b[i] = '0;
      end
    end else begin
      for (int i = N-1; i > 0; i--) begin
        hist_a[i] = hist_a[i-1];
        hist_b[i] = hist_b[i-1];
      end
      hist_a[0] = (in_valid && exp_ready) ? a_vec : '0;
      hist_b[0] = (in_valid && exp_ready) ? b_vec : '0;
    end
    for (int i = N-1; i >= 0; i--) begin
      for (int j = N-1; j >= 0; j--) begin
        m_ain = (j == 0) ? a_edge[i*DW +: DW] : ar[i][j-1];
        m_bin = (i == 0) ? b_edge[j*DW +: DW] : br[i-1][j];
        if (!pe_clr_n) acc[i][j] = 0;
        else if (pe_enable) acc[i][j] = acc[i][j] + int'(m_ain) * int'(m_bin);
        ar[i][j] = m_ain;
        br[i][j] = m_bin;
      end
    end
  end

  initial forever begin
    logic [N*DW-1:0] ea, eb;
    @(negedge clk);
    if (chk_on) begin
      for (int i = 0; i < N; i++) begin
        ea[i*DW +: DW] = hist_a[i][i*DW +: DW];
        eb[i*DW +: DW] = hist_b[i][i*DW +: DW];
      end
      chk("a_edge", a_edge, ea);
      chk("b_edge", b_edge, eb);
    end
  end

  task automatic fill(input int mode, input int k);
    for (int i = 0; i < N; i++)
      for (int kk = 0; kk < K_MAX; kk++) begin
        ma[i][kk] = '0;
        mb[kk][i] = '0;
      end
    for (int kk = 0; kk < k; kk++)
      for (int i = 0; i < N; i++) begin
        case (mode)
          0: begin ma[i][kk] = 16'sd1; mb[kk][i] = 16'sd1; end
          1: begin ma[i][kk] = DW'(i + 1); mb[kk][i] = DW'(i + 5); end
          2: begin ma[i][kk] = -16'sd32768; mb[kk][i] = -16'sd32768; end
          default: begin ma[i][kk] = DW'($urandom); mb[kk][i] = DW'($urandom); end
        endcase
      end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ref_p[i][j] = 0;
        for (int kk = 0; kk < k; kk++) ref_p[i][j] = ref_p[i][j] + int'(ma[i][kk]) * int'(mb[kk][j]);
      end
  endtask

  task automatic check_psums();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        chk($sformatf("psum%0d%0d", i, j), acc[i][j], ref_p[i][j]);
  endtask

  task automatic drive_step(input int idx);
    for (int i = 0; i < N; i++) begin
      a_vec[i*DW +: DW] = ma[i][idx];
      b_vec[i*DW +: DW] = mb[idx][i];
    end
  endtask

  // d counts cycles after the start edge; CLEAR is d=1, FEED starts at d=2.
  task automatic run_tile(input int k, input bit rand_valid, input bit poke,
                          output int done_d, output int stalls);
    int hs;
    bit in_feed;
    hs = 0;
    stalls = 0;
    done_d = -1;
    @(negedge clk);
    start = 1'b1; k_len = KW'(k); in_valid = 1'b0; exp_ready = 1'b0;
    @(posedge clk);
    for (int d = 1; d <= 300; d++) begin
      @(negedge clk);
      start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
      in_feed = (d >= 2) && (hs < k);
      if (d == 1) chk("clr_n_in_clear", pe_clr_n, 0);
      if (d == 2) chk("clr_n_after_clear", pe_clr_n, 1);
      chk("in_ready", in_ready, in_feed);
      chk("busy", busy, 1);
      if (done) begin
        chk("pe_enable_done", pe_enable, 0);
        done_d = d;
        break;
      end
      chk("pe_enable", pe_enable, (d >= 2) && (k > 0));
      exp_ready = in_feed;
      if (in_feed) begin
        if (!rand_valid || stalls > 100 || $urandom_range(0, 1) == 1) begin
          in_valid = 1'b1;
          drive_step(hs);
          hs++;
        end else begin
          in_valid = 1'b0;
          a_vec = {$urandom, $urandom};
          b_vec = {$urandom, $urandom};
          stalls++;
        end
      end else begin
        in_valid = poke ? 1'($urandom_range(0, 1)) : 1'b0;
        a_vec = {$urandom, $urandom};
        b_vec = {$urandom, $urandom};
      end
    end
    if (done_d < 0) chk("done_timeout", 0, 1);
    exp_ready = 1'b0;
    in_valid = 1'b0;
    start = poke;
    @(negedge clk);
    start = 1'b0;
    chk("done_pulse_len", done, 0);
    chk("idle_after_done", busy, 0);
    chk("in_ready_idle", in_ready, 0);
    @(negedge clk);
    chk("start_in_done_ignored", busy, 0);
    chk("clr_n_idle", pe_clr_n, 1);
  endtask

  initial begin
    int dd, st;
    tbl[0] = '{k: 4, fill: 0, lat: 13, p00: 4, p33: 4};
    tbl[1] = '{k: 1, fill: 1, lat: 10, p00: 5, p33: 32};
    tbl[2] = '{k: 2, fill: 2, lat: 11, p00: int'(32'h8000_0000), p33: int'(32'h8000_0000)};
    tbl[3] = '{k: 0, fill: 0, lat: 2, p00: 0, p33: 0};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; k_len = '0; a_vec = '0; b_vec = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ar[i][j] = '0; br[i][j] = '0; acc[i][j] = 0;
      end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_pe_enable", pe_enable, 0);
    chk("rst_pe_clr_n", pe_clr_n, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_a_edge", a_edge, 0);
    chk("rst_b_edge", b_edge, 0);
    rst = 1'b0;
    chk_on = 1'b1;
    @(negedge clk);
    chk("clr_n_released", pe_clr_n, 1);

    for (int t = 0; t < 4; t++) begin
      fill(tbl[t].fill, tbl[t].k);
      run_tile(tbl[t].k, 1'b0, 1'b0, dd, st);
      chk($sformatf("tbl%0d_latency", t), dd, tbl[t].lat);
      chk($sformatf("tbl%0d_p00", t), acc[0][0], tbl[t].p00);
      chk($sformatf("tbl%0d_p33", t), acc[N-1][N-1], tbl[t].p33);
      check_psums();
    end

    for (int r = 0; r < 3; r++) begin
      fill(3, 8);
      run_tile(8, 1'b1, 1'b1, dd, st);
      chk("rand_latency", dd, 17 + st);
      check_psums();
    end

    // Reset after two of four handshakes, then a clean tile.
    fill(3, 4);
    @(negedge clk);
    start = 1'b1; k_len = KW'(4);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int h = 0; h < 2; h++) begin
      @(negedge clk);
      chk("mid_in_ready", in_ready, 1);
      exp_ready = 1'b1;
      in_valid = 1'b1;
      drive_step(h);
    end
    @(negedge clk);
    exp_ready = 1'b0;
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_a_edge", a_edge, 0);
    chk("mid_rst_b_edge", b_edge, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_pe_enable", pe_enable, 0);
    chk("mid_rst_clr_n", pe_clr_n, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_acc", acc[N-1][N-1], 0);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("no_done_after_rst", {busy, done}, 0);
    end
    run_tile(4, 1'b0, 1'b0, dd, st);
    chk("post_rst_latency", dd, 4 + 2*N + 1);
    check_psums();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
